// File: rtl/acc_drain_quantizer.sv
// Accumulator drain: reads a run of accumulator rows, applies ReLU, a rounding shift
// and int8 saturation per lane, and streams packed rows out through a 2-entry FIFO.
module acc_drain_quantizer #(
    parameter int DATA_SIZE = 20,
    parameter int DATA_NUM  = 16,
    parameter int OUT_SIZE  = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W:0]               row_cnt,
    input  logic [4:0]                    shift,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          done,
    output logic                          acc_enb,
    output logic [ADDR_W-1:0]             acc_addrb,
    input  logic [DATA_NUM*DATA_SIZE-1:0] acc_doutb,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_NUM*OUT_SIZE-1:0]  out_data,
    output logic [ADDR_W:0]               out_idx,
    output logic                          out_last
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam int                      MID_W     = DATA_SIZE + 1;
    localparam logic [4:0]              SHIFT_MAX = 5'(DATA_SIZE - 1);
    localparam logic signed [MID_W-1:0] SAT_MAX   = MID_W'((1 << (OUT_SIZE - 1)) - 1);
    localparam logic signed [MID_W-1:0] SAT_MIN   = ~SAT_MAX;

    function automatic logic signed [MID_W-1:0] relu_clip(
        input logic signed [DATA_SIZE-1:0] x, input logic en);
        logic signed [MID_W-1:0] v;
        v = {x[DATA_SIZE-1], x};
        if (en && v[MID_W-1]) v = '0;
        return v;
    endfunction

    // Round half up: adding 2^(s-1) before the arithmetic shift; one guard bit absorbs the carry.
    function automatic logic signed [MID_W-1:0] round_shift(
        input logic signed [MID_W-1:0] v, input logic [4:0] s);
        logic signed [MID_W-1:0] half;
        if (s == 5'd0) return v;
        half = '0;
        half[s - 5'd1] = 1'b1;
        return (v + half) >>> s;
    endfunction

    function automatic logic signed [OUT_SIZE-1:0] sat_lane(input logic signed [MID_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUT_SIZE-1:0];
        if (v < SAT_MIN) return SAT_MIN[OUT_SIZE-1:0];
        return v[OUT_SIZE-1:0];
    endfunction

    logic [1:0]                   state;
    logic [ADDR_W-1:0]            base_r;
    logic [ADDR_W:0]              cnt_r;
    logic [ADDR_W:0]              k_r;
    logic [4:0]                   shift_r;
    logic                         relu_r;
    logic                         vld_p0;
    logic [ADDR_W:0]              idx_p0;
    logic                         last_p0;
    logic [DATA_NUM*OUT_SIZE-1:0] quant_p1;
    logic [DATA_NUM*OUT_SIZE-1:0] fifo_data [2];
    logic [ADDR_W:0]              fifo_idx [2];
    logic [1:0]                   fifo_last;
    logic                         rd_ptr;
    logic [1:0]                   fifo_count;
    logic                         issue;
    logic                         last_issue;
    logic                         push;
    logic                         pop;
    logic                         wr_ptr;

    // A read is only issued if the FIFO has room for it plus whatever is already in flight.
    assign issue      = (state == RUN) && ((fifo_count + {1'b0, vld_p0}) < 2'd2);
    assign last_issue = (k_r == cnt_r - 1'b1);
    assign push       = vld_p0;
    assign pop        = out_valid && out_ready;
    assign wr_ptr     = rd_ptr ^ fifo_count[0];

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign acc_enb   = vld_p0;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_idx   = fifo_idx[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];

    // p0: command control and read issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_r    <= '0;
            cnt_r     <= '0;
            k_r       <= '0;
            shift_r   <= '0;
            relu_r    <= 1'b0;
            vld_p0    <= 1'b0;
            idx_p0    <= '0;
            last_p0   <= 1'b0;
            acc_addrb <= '0;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base_r  <= base_addr;
                    cnt_r   <= row_cnt;
                    shift_r <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
                    relu_r  <= relu_en;
                    k_r     <= '0;
                    state   <= (row_cnt == '0) ? FIN : RUN;
                end
                RUN: if (issue) begin
                    vld_p0    <= 1'b1;
                    acc_addrb <= base_r + k_r[ADDR_W-1:0];
                    idx_p0    <= k_r;
                    last_p0   <= last_issue;
                    k_r       <= k_r + 1'b1;
                    if (last_issue) state <= DRAIN;
                end
                DRAIN: if (fifo_count == 2'd0 && !vld_p0) state <= FIN;
                default: state <= IDLE;
            endcase
        end
    end

    // p1: returned row is quantized and pushed on the edge after the read
    always_comb begin
        quant_p1 = '0;
        for (int i = 0; i < DATA_NUM; i++) begin
            quant_p1[i*OUT_SIZE +: OUT_SIZE] = sat_lane(round_shift(
                relu_clip(acc_doutb[i*DATA_SIZE +: DATA_SIZE], relu_r), shift_r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
            fifo_last  <= '0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= quant_p1;
                fifo_idx[wr_ptr]  <= idx_p0;
                fifo_last[wr_ptr] <= last_p0;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_acc_drain_quantizer.sv
// Bench for acc_drain_quantizer: directed command scenarios plus randomized commands
// checked against an arithmetic per-lane model and an accumulator memory model.
module tb_acc_drain_quantizer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   base_addr;
    logic [4:0]   row_cnt;
    logic [4:0]   shift;
    logic         relu_en;
    logic         busy;
    logic         done;
    logic         acc_enb;
    logic [3:0]   acc_addrb;
    logic [319:0] acc_doutb = '0;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_idx;
    logic         out_last;

    logic [319:0] acc_mem [16];
    logic [127:0] got_q [$];
    int           total = 0;
    int           bad = 0;
    int           stall_enb;
    int           first_valid_c;

    acc_drain_quantizer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .row_cnt(row_cnt), .shift(shift), .relu_en(relu_en), .busy(busy),
        .done(done), .acc_enb(acc_enb), .acc_addrb(acc_addrb), .acc_doutb(acc_doutb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Accumulator memory: read data changes on the falling edge after an enabled read.
    always @(negedge clk) if (acc_enb) acc_doutb <= acc_mem[acc_addrb];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_lane(input int x_in, input bit relu, input int sh_in);
        int x, sh, d, n, q;
        x  = x_in;
        sh = (sh_in > 19) ? 19 : sh_in;
        if (relu && x < 0) x = 0;
        if (sh > 0) begin
            d = 1 << sh;
            n = x + d / 2;
            q = n / d;
            if (n % d != 0 && n < 0) q = q - 1;
            x = q;
        end
        if (x > 127) x = 127;
        if (x < -128) x = -128;
        return x;
    endfunction

    function automatic logic [127:0] ref_row(input int addr, input bit relu, input int sh);
        logic [127:0]       row;
        logic [319:0]       src;
        logic signed [19:0] lane;
        int                 r;
        src = acc_mem[addr];
        for (int i = 0; i < 16; i++) begin
            lane = src[i*20 +: 20];
            r = ref_lane(int'(lane), relu, sh);
            row[i*8 +: 8] = r[7:0];
        end
        return row;
    endfunction

    function automatic logic [19:0] rnd_lane();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 600)) - 300;
            1: v = int'($urandom);
            2: v = ($urandom_range(0, 1) != 0) ? 524287 : -524288;
            default: v = int'($urandom_range(0, 60)) - 30;
        endcase
        return v[19:0];
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 16; r++)
            for (int l = 0; l < 16; l++) acc_mem[r][l*20 +: 20] = rnd_lane();
    endtask

    task automatic set_lane(input int row, input int lane, input int v);
        acc_mem[row][lane*20 +: 20] = v[19:0];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_enb"}, acc_enb, 0);
        chk({tag, "_addr"}, acc_addrb, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    // One drain command; stall = cycles of out_ready low, rnd_rdy = random ready after,
    // glitch_c = cycle at which a conflicting start pulse is raised (-1 for none).
    task automatic run_cmd(input int base, input int cnt, input int sh, input bit relu,
                           input int stall, input bit rnd_rdy, input int glitch_c);
        logic [127:0] exp_rows [$];
        logic [127:0] prev_data;
        logic [4:0]   prev_idx;
        bit           prev_stall = 0;
        bit           done_seen = 0;
        int           n_addr = 0;
        int           n_acc = 0;
        int           done_c = -1;
        int           last_edge = -1;
        for (int k = 0; k < cnt; k++) exp_rows.push_back(ref_row((base + k) % 16, relu, sh));
        got_q.delete();
        stall_enb = 0;
        first_valid_c = -1;
        @(negedge clk);
        start = 1'b1; base_addr = base[3:0]; row_cnt = cnt[4:0];
        shift = sh[4:0]; relu_en = relu;
        for (int c = 0; c < 600 && !done_seen; c++) begin
            @(negedge clk);
            start = (c == glitch_c);
            if (c == glitch_c) begin
                base_addr = base_addr + 4'd5; row_cnt = 5'd3; shift = 5'd7; relu_en = ~relu;
            end
            if (acc_enb) begin
                chk("acc_addr", acc_addrb, (base + n_addr) % 16);
                n_addr++;
                if (c < stall) stall_enb++;
            end
            if (out_valid && first_valid_c < 0) first_valid_c = c;
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_idx", out_idx, prev_idx);
            end
            if (done) begin
                done_seen = 1;
                done_c = c;
                chk("done_after_rows", n_acc, cnt);
            end
            out_ready = (c >= stall) && (!rnd_rdy || $urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                chk("row_in_range", n_acc < cnt, 1);
                if (n_acc < cnt) begin
                    chk("out_data", out_data, exp_rows[n_acc]);
                    chk("out_idx", out_idx, n_acc);
                    chk("out_last", out_last, n_acc == cnt - 1);
                end
                got_q.push_back(out_data);
                n_acc++;
                last_edge = c + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
        chk("done_seen", done_seen, 1);
        chk("rows_accepted", n_acc, cnt);
        chk("reads_issued", n_addr, cnt);
        chk("done_latency", done_c, last_edge + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_enb", acc_enb, 0);
        end
    endtask

    initial begin
        logic [127:0] row;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; row_cnt = '0; shift = '0;
        relu_en = 1'b0; out_ready = 1'b0;
        for (int r = 0; r < 16; r++) acc_mem[r] = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Saturation and sign handling with no shift
        fill_random();
        set_lane(0, 0, 100); set_lane(0, 1, -5); set_lane(0, 2, 300); set_lane(0, 3, -300);
        run_cmd(0, 1, 0, 0, 0, 0, -1);
        row = got_q[0];
        chk("t1_lanes", row[31:0], 32'h807F_FB64);

        // Round half up, with and without ReLU
        set_lane(5, 0, 24); set_lane(5, 1, 23); set_lane(5, 2, -24); set_lane(5, 3, -8);
        run_cmd(5, 1, 4, 0, 0, 0, -1);
        row = got_q[0];
        chk("t2_round", row[31:0], 32'h00FF_0102);
        run_cmd(5, 1, 4, 1, 0, 0, -1);
        row = got_q[0];
        chk("t2_relu", row[31:0], 32'h0000_0102);

        // Address wrap and first-valid latency
        fill_random();
        run_cmd(14, 4, 2, 0, 0, 0, -1);
        chk("t3_first_valid", first_valid_c, 2);

        // Backpressure: reads limited by the FIFO credit
        run_cmd(3, 8, 6, 1, 10, 0, -1);
        chk("t4_stall_enb", stall_enb <= 2, 1);

        // Empty command and a start pulse while busy
        run_cmd(7, 0, 3, 0, 0, 0, 0);
        run_cmd(9, 6, 5, 0, 0, 1, 3);

        // Randomized commands, including shifts beyond the clamp
        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_cmd($urandom_range(0, 15), $urandom_range(1, 16), $urandom_range(0, 31),
                    $urandom_range(0, 1), (t % 3 == 0) ? $urandom_range(0, 8) : 0, 1, -1);
        end

        // Reset in the middle of a long command
        fill_random();
        @(negedge clk);
        start = 1'b1; base_addr = 4'd2; row_cnt = 5'd16; shift = 5'd3; relu_en = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", done, 0);
            chk("t6_idle", busy, 0);
        end
        run_cmd(11, 16, 5, 1, 0, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
